exp_align_sched: RTL and testbench
==================================

Name: exp_align_sched

Overview:
- Block-floating-point alignment scheduler for the hadamard small-float datapath.
- Collects a block of 2-lane exponent beats into a local buffer and tracks the block maximum exponent.
- Replays the buffered beats, each paired with per-lane right-shift offsets relative to that maximum, to the mantissa aligners downstream.
- Zero exponent codes (zero/denormal) produce a fixed flush shift.

Parameters:
- EXP_W, 4, exponent field width per lane
- BLOCK_LEN, 8, maximum beats per block (buffer depth, ≥2)
- ZERO_SHIFT, 9, offset emitted for an exponent code of 0; must be ≤ 2^EXP_W-1
- CNT_W, $clog2(BLOCK_LEN)+1, beat counter width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort: discard current block
- in_valid  in  1  input beat valid
- in_ready  out  1  scheduler can accept a beat
- in_exp  in  2*EXP_W  lane1 in [2*EXP_W-1:EXP_W], lane0 in [EXP_W-1:0]
- in_last  in  1  final beat of block (early block close)
- out_valid  out  1  offset beat valid
- out_ready  in  1  downstream accepts beat
- out_offset  out  2*EXP_W  per-lane shift amounts, same lane packing as in_exp
- out_max  out  EXP_W  block maximum exponent, constant for the whole emit phase
- out_last  out  1  final beat of block
- out_idx  out  CNT_W  beat index within block, 0-based

Behaviour:
- Reset: asynchronous, active-low.
  - State = COLLECT.
  - in_ready = 1.
  - out_valid = 0, out_offset = 0, out_max = 0, out_last = 0, out_idx = 0.
  - Count = 0, running max = 0.
  - Buffer contents: don't-care.
- Two states.
- COLLECT:
  - in_ready = 1.
  - A beat is accepted when in_valid & in_ready: buf[count] <= in_exp; count++; max <= max(max, lane0, lane1).
    - The max update includes the beat being accepted.
    - Zero lanes never raise the max.
  - Transition to EMIT on the accepting edge when in_last = 1 or count == BLOCK_LEN-1.
  - The block length L is latched as count+1.
- EMIT:
  - in_ready = 0.
  - out_valid rises on the first cycle after the transition, so the first output appears one cycle after the final input handshake.
  - Per lane: out_offset = (exp == 0) ? ZERO_SHIFT : max - exp. The result always fits in EXP_W bits with no wrap.
  - Outputs are registered.
  - out_offset, out_idx and out_last hold stable while out_valid & !out_ready.
  - Each out handshake advances the read index. The next beat is presented in the following cycle, with no bubble between beats.
  - out_last = 1 exactly when out_idx == L-1.
  - After the last beat's handshake:
    - out_valid = 0 next cycle.
    - State returns to COLLECT with count = 0 and max = 0.
    - in_ready = 1 in that same next cycle.
- All-zero block: max = 0 and every offset = ZERO_SHIFT.
- Single-beat block (in_last on the first beat): L = 1, and out_last is asserted on idx 0.
- in_last when count == BLOCK_LEN-1: same transition; the two conditions are not double-counted.
- flush (any state, priority over all handshakes):
  - Next cycle: COLLECT, count = 0, max = 0, out_valid = 0, in_ready = 1.
  - A beat presented in the flush cycle is dropped.
- Reset mid-EMIT: outputs drop immediately (asynchronously); no partial block resumes.
- in_valid is ignored in EMIT, since in_ready = 0.
- out_ready is ignored when out_valid = 0.

Decomposition:
- Shared package hadamard_pkg holds:
  - the state enum {ST_COLLECT, ST_EMIT};
  - the ZERO_SHIFT default constant;
  - the EXP_W default.
- Sub-module exp_offset_calc:
  - Purely combinational, one lane.
  - Inputs exp and max; output offset with the zero→ZERO_SHIFT rule.
  - Instantiated twice from a generate loop over lanes.
- The scheduler owns the FSM, counters, buffer, max tracker and output registers.

Test Plan:
- Full block:
  - Stimulus: 8 beats, lanes (lane1,lane0) = (3,5), (7,2), (0,4), (6,6), (1,1), (2,0), (5,3), (4,7); no backpressure.
  - Response: out_max = 7; offsets (4,2), (0,5), (9,3), (1,1), (6,6), (5,9), (2,4), (3,0); out_last on idx 7; first out_valid 1 cycle after the 8th input handshake; in_ready = 1 the cycle after the 8th output handshake.
- Early close: 3 beats (2,2), (9,1), (4,0) with in_last on beat 3 → max = 9; offsets (7,7), (0,8), (5,9); out_last on idx 2; L = 3.
- All-zero block: 2 beats (0,0), (0,0) with in_last → out_max = 0; both offsets (9,9).
- Backpressure: out_ready = 0 for 4 cycles mid-block, then 1 → outputs hold stable, no beat lost or duplicated, and the index sequence is contiguous 0..L-1.
- Flush mid-EMIT after 2 output beats → out_valid = 0 next cycle; in_ready = 1. The next block of 1 beat (8,15) with in_last gives max = 15, offsets (7,0).
- Async reset: assert rst_n = 0 mid-COLLECT between clock edges → outputs clear immediately, without waiting for a clock edge. After release, a fresh block behaves as in the first scenario.

Source files
------------

// File: rtl/hadamard_pkg.sv
// hadamard_pkg: shared types and defaults for the hadamard small-float datapath.
package hadamard_pkg;
   typedef enum logic {ST_COLLECT, ST_EMIT} state_t;
   localparam int EXP_W_DEF = 4;
   localparam int ZERO_SHIFT_DEF = 9;
endpackage

// File: rtl/exp_offset_calc.sv
// exp_offset_calc: per-lane right-shift offset relative to the block maximum exponent.
module exp_offset_calc import hadamard_pkg::*; #(
   parameter int EXP_W = EXP_W_DEF,
   parameter int ZERO_SHIFT = ZERO_SHIFT_DEF
) (
   input  logic [EXP_W-1:0] exp,
   input  logic [EXP_W-1:0] max,
   output logic [EXP_W-1:0] offset
);
   assign offset = (exp == '0) ? EXP_W'(ZERO_SHIFT) : max - exp;
endmodule

// File: rtl/exp_align_sched.sv
// exp_align_sched: buffers a block of 2-lane exponent beats, then replays them with
// per-lane shift offsets relative to the block maximum exponent.
module exp_align_sched import hadamard_pkg::*; #(
   parameter int EXP_W = EXP_W_DEF,
   parameter int BLOCK_LEN = 8,
   parameter int ZERO_SHIFT = ZERO_SHIFT_DEF,
   localparam int CNT_W = $clog2(BLOCK_LEN) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*EXP_W-1:0] in_exp,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*EXP_W-1:0] out_offset,
   output logic [EXP_W-1:0]   out_max,
   output logic               out_last,
   output logic [CNT_W-1:0]   out_idx
);
   localparam int AW = $clog2(BLOCK_LEN);
   state_t state, state_n;
   logic [CNT_W-1:0] count, nxt_idx;
   logic [EXP_W-1:0] max_r, lane_max, new_max, calc_max;
   logic [2*EXP_W-1:0] mem [BLOCK_LEN];
   logic [2*EXP_W-1:0] calc_exp, nxt_offset;
   logic accept, close, hs, done;
   assign in_ready = state == ST_COLLECT;
   assign accept = in_valid & in_ready;
   assign close = accept & (in_last | count == CNT_W'(BLOCK_LEN - 1));
   assign hs = out_valid & out_ready;
   assign done = hs & out_last;
   assign nxt_idx = out_idx + CNT_W'(1);
   assign lane_max = (in_exp[2*EXP_W-1:EXP_W] > in_exp[EXP_W-1:0]) ? in_exp[2*EXP_W-1:EXP_W] : in_exp[EXP_W-1:0];
   assign new_max = (lane_max > max_r) ? lane_max : max_r;
   assign out_max = max_r;
   // On the closing beat, beat 0 may be the one still on the input bus.
   assign calc_exp = in_ready ? ((count == '0) ? in_exp : mem[0]) : mem[nxt_idx[AW-1:0]];
   assign calc_max = in_ready ? new_max : max_r;
   for (genvar l = 0; l < 2; l++) begin : g_lane
      exp_offset_calc #(.EXP_W(EXP_W), .ZERO_SHIFT(ZERO_SHIFT)) u_calc (
         .exp    (calc_exp[l*EXP_W +: EXP_W]),
         .max    (calc_max),
         .offset (nxt_offset[l*EXP_W +: EXP_W])
      );
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ST_COLLECT;
      else state <= state_n;
   always_comb begin
      state_n = state;
      if (flush) state_n = ST_COLLECT;
      else if (close) state_n = ST_EMIT;
      else if (done) state_n = ST_COLLECT;
   end
   always_ff @(posedge clk)
      if (accept && !flush) mem[count[AW-1:0]] <= in_exp;
   // During emit, count holds the latched block length.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {count, max_r, out_valid, out_offset, out_last, out_idx} <= '0;
      else if (flush || done) {count, max_r, out_valid, out_offset, out_last, out_idx} <= '0;
      else if (accept) begin
         count <= count + CNT_W'(1);
         max_r <= new_max;
         if (close) begin
            out_valid <= 1'b1;
            out_offset <= nxt_offset;
            out_idx <= '0;
            out_last <= count == '0;
         end
      end else if (hs) begin
         out_idx <= nxt_idx;
         out_offset <= nxt_offset;
         out_last <= nxt_idx == count - CNT_W'(1);
      end
endmodule

// File: tb/tb_exp_align_sched.sv
// tb_exp_align_sched: scoreboard bench for the block exponent alignment scheduler.
module tb_exp_align_sched;
   logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_last = 0, out_ready = 1;
   logic [7:0] in_exp = '0;
   logic in_ready, out_valid, out_last;
   logic [7:0] out_offset;
   logic [3:0] out_max, out_idx;
   int errs = 0, checks = 0, npop = 0;
   typedef struct packed {logic [7:0] off; logic [3:0] mx; logic last; logic [3:0] idx;} exp_t;
   exp_t q[$];
   exp_t e;
   logic [7:0] blk [8];
   always #5 clk = ~clk;
   exp_align_sched dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_exp(in_exp), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_offset(out_offset), .out_max(out_max), .out_last(out_last), .out_idx(out_idx)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask
   function automatic logic [3:0] ofs(input logic [3:0] x, input logic [3:0] m);
      return (x == 0) ? 4'd9 : m - x;
   endfunction
   task automatic model(input int n);
      logic [3:0] m;
      m = 0;
      for (int i = 0; i < n; i++) begin
         if (blk[i][3:0] > m) m = blk[i][3:0];
         if (blk[i][7:4] > m) m = blk[i][7:4];
      end
      for (int i = 0; i < n; i++)
         q.push_back('{off: {ofs(blk[i][7:4], m), ofs(blk[i][3:0], m)}, mx: m, last: (i == n - 1), idx: i[3:0]});
   endtask
   always @(negedge clk)
      if (rst_n && !flush && out_valid) begin
         if (q.size() == 0) chk("extra_beat", q.size(), 1);
         else if (out_ready) begin
            e = q.pop_front();
            npop++;
            chk("offset", out_offset, e.off);
            chk("max", out_max, e.mx);
            chk("last", out_last, e.last);
            chk("idx", out_idx, e.idx);
         end else begin
            chk("hold_offset", out_offset, q[0].off);
            chk("hold_idx", out_idx, q[0].idx);
         end
      end
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send(input int n, input bit with_last, input bit push);
      int t;
      if (push) model(n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1;
         in_exp = blk[i];
         in_last = with_last && (i == n - 1);
         t = 0;
         while (!in_ready && t < 50) begin
            cyc(1);
            t++;
         end
         if (!in_ready) chk("in_ready_timeout", in_ready, 1);
         cyc(1);
      end
      in_valid = 0;
      in_last = 0;
   endtask
   task automatic drain(input string tag);
      int t;
      t = 0;
      while (out_valid && t < 300) begin
         cyc(1);
         t++;
      end
      in_valid = 0;
      in_exp = '0;
      chk({tag, "_done"}, out_valid, 0);
      chk({tag, "_ready"}, in_ready, 1);
      chk({tag, "_qempty"}, q.size(), 0);
   endtask
   task automatic wait_pops(input int n);
      int t, base;
      t = 0;
      base = npop;
      while (npop < base + n && t < 100) begin
         cyc(1);
         t++;
      end
      chk("pop_timeout", npop, base + n);
   endtask
   task automatic load_full();
      blk = '{8'h35, 8'h72, 8'h04, 8'h66, 8'h11, 8'h20, 8'h53, 8'h47};
   endtask
   task automatic full_block(input string tag);
      load_full();
      send(8, 0, 1);
      chk({tag, "_first_valid"}, out_valid, 1);
      chk({tag, "_busy"}, in_ready, 0);
      drain(tag);
   endtask
   initial begin
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_offset", out_offset, 0);
      chk("rst_max", out_max, 0);
      chk("rst_last", out_last, 0);
      chk("rst_idx", out_idx, 0);
      cyc(1);
      rst_n = 1;
      full_block("full");
      load_full();
      send(8, 0, 1);
      wait_pops(2);
      out_ready = 0;
      in_valid = 1;
      in_exp = 8'hFF;
      cyc(4);
      chk("bp_valid", out_valid, 1);
      out_ready = 1;
      drain("bp");
      blk[0] = 8'h22; blk[1] = 8'h91; blk[2] = 8'h40;
      send(3, 1, 1);
      drain("early");
      blk[0] = 8'h00; blk[1] = 8'h00;
      send(2, 1, 1);
      drain("zero");
      blk[0] = 8'h12; blk[1] = 8'h34; blk[2] = 8'h56; blk[3] = 8'h70;
      send(4, 1, 1);
      wait_pops(2);
      out_ready = 0;
      flush = 1;
      q.delete();
      cyc(1);
      flush = 0;
      out_ready = 1;
      chk("fl_valid", out_valid, 0);
      chk("fl_ready", in_ready, 1);
      chk("fl_max", out_max, 0);
      blk[0] = 8'h8F;
      send(1, 1, 1);
      drain("single");
      load_full();
      send(8, 0, 1);
      wait_pops(1);
      #2 rst_n = 0;
      q.delete();
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_offset", out_offset, 0);
      chk("arst_max", out_max, 0);
      chk("arst_idx", out_idx, 0);
      chk("arst_ready", in_ready, 1);
      cyc(1);
      rst_n = 1;
      blk[0] = 8'hFF; blk[1] = 8'h3C;
      send(2, 0, 0);
      chk("pre_rst_max", out_max, 15);
      #2 rst_n = 0;
      #1;
      chk("crst_max", out_max, 0);
      chk("crst_valid", out_valid, 0);
      cyc(1);
      rst_n = 1;
      full_block("post_rst");
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
